// File: rtl/motion_pkg.sv
// Shared motion-control definitions: sequencer states, step table and
// default encoder/setpoint widths used by the sequencer and the PID.
package motion_pkg;

  localparam int POS_W_DEF = 13;
  localparam int SP_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MOVE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DWELL  = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  function automatic logic [SP_W_DEF-1:0] step_target(input logic [1:0] idx);
    logic [SP_W_DEF-1:0] val;
    case (idx)
      2'd0:    val = 16'd374;
      2'd1:    val = 16'd748;
      2'd2:    val = 16'd1122;
      2'd3:    val = 16'd195;
      default: val = 16'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/err_window.sv
// Signed position error (setpoint minus zero-extended encoder count) and the
// in-position window test; purely combinational.
module err_window
  import motion_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int SP_W  = SP_W_DEF,
  parameter int TOL   = 10
) (
  input  logic [SP_W-1:0]  setpoint,
  input  logic [POS_W-1:0] position,
  output logic             in_win
);

  localparam logic [SP_W:0] TOL_V = (SP_W+1)'(TOL);

  logic signed [SP_W:0] error;
  logic        [SP_W:0] mag;

  // One extra bit keeps both operands non-negative, so the full encoder range never aliases the sign
  always_comb begin
    error = $signed({1'b0, setpoint}) - $signed({{(SP_W + 1 - POS_W){1'b0}}, position});
    if (error[SP_W]) begin
      mag = $unsigned(-error);
    end else begin
      mag = $unsigned(error);
    end
    in_win = (mag <= TOL_V);
  end

endmodule

// File: rtl/setpoint_sequencer.sv
// Steps the PID setpoint through the motion table, waiting for each target to
// settle and dwell, with a move timeout that latches a fault.
module setpoint_sequencer
  import motion_pkg::*;
#(
  parameter int POS_W        = POS_W_DEF,
  parameter int SP_W         = SP_W_DEF,
  parameter int TOL          = 10,
  parameter int SETTLE_CYC   = 50000,
  parameter int DWELL_CYC    = 1000000,
  parameter int MOVE_TIMEOUT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [POS_W-1:0] i_position,
  output logic [SP_W-1:0]  o_setpoint,
  output logic             o_pid_rst,
  output logic             o_motor_en,
  output logic [1:0]       o_step,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout
);

  localparam int TMO_W = $clog2(MOVE_TIMEOUT + 1);
  localparam int STL_W = $clog2(SETTLE_CYC + 1);
  localparam int DWL_W = $clog2(DWELL_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MOVE_TIMEOUT);
  localparam logic [STL_W-1:0] STL_MAX = STL_W'(SETTLE_CYC);
  localparam logic [DWL_W-1:0] DWL_MAX = DWL_W'(DWELL_CYC);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt, tmo_inc;
  logic [STL_W-1:0] settle_cnt, settle_inc;
  logic [DWL_W-1:0] dwell_cnt, dwell_inc;
  logic             tmo_hit, settle_hit, dwell_hit;
  logic             in_win;

  err_window #(
    .POS_W (POS_W),
    .SP_W  (SP_W),
    .TOL   (TOL)
  ) u_err (
    .setpoint (o_setpoint),
    .position (i_position),
    .in_win   (in_win)
  );

  // Saturating next-count values; the counters stop at their terminal value
  always_comb begin
    tmo_inc    = (tmo_cnt    >= TMO_MAX) ? TMO_MAX : tmo_cnt    + TMO_W'(1);
    settle_inc = (settle_cnt >= STL_MAX) ? STL_MAX : settle_cnt + STL_W'(1);
    dwell_inc  = (dwell_cnt  >= DWL_MAX) ? DWL_MAX : dwell_cnt  + DWL_W'(1);
    tmo_hit    = (tmo_inc    >= TMO_MAX);
    settle_hit = (settle_inc >= STL_MAX);
    dwell_hit  = (dwell_inc  >= DWL_MAX);
  end

  // Sequencer FSM; outputs are updated on the same edge as the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      o_setpoint <= '0;
      o_pid_rst  <= 1'b1;
      o_motor_en <= 1'b0;
      o_step     <= 2'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
    end else if (i_abort) begin
      state      <= ST_IDLE;
      o_pid_rst  <= 1'b1;
      o_motor_en <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_pid_rst  <= 1'b1;
          o_motor_en <= 1'b0;
          o_done     <= 1'b0;
          if (i_start) begin
            state  <= ST_LOAD;
            o_step <= 2'd0;
            o_busy <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          state      <= ST_MOVE;
          o_setpoint <= SP_W'(step_target(o_step));
          tmo_cnt    <= '0;
          o_pid_rst  <= 1'b0;
          o_motor_en <= 1'b1;
          o_busy     <= 1'b1;
        end
        ST_MOVE: begin
          tmo_cnt <= tmo_inc;
          if (tmo_hit) begin
            state      <= ST_FAULT;
            o_timeout  <= 1'b1;
            o_motor_en <= 1'b0;
            o_pid_rst  <= 1'b1;
            o_busy     <= 1'b0;
          end else if (in_win) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end else begin
            state <= ST_MOVE;
          end
        end
        // The move timer keeps running across SETTLE->MOVE bounces
        ST_SETTLE: begin
          tmo_cnt <= tmo_inc;
          if (tmo_hit) begin
            state      <= ST_FAULT;
            o_timeout  <= 1'b1;
            o_motor_en <= 1'b0;
            o_pid_rst  <= 1'b1;
            o_busy     <= 1'b0;
          end else if (!in_win) begin
            state <= ST_MOVE;
          end else begin
            settle_cnt <= settle_inc;
            if (settle_hit) begin
              state     <= ST_DWELL;
              dwell_cnt <= '0;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_DWELL: begin
          dwell_cnt <= dwell_inc;
          if (dwell_hit) begin
            if (o_step == 2'd3) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state      <= ST_LOAD;
              o_step     <= o_step + 2'd1;
              o_pid_rst  <= 1'b1;
              o_motor_en <= 1'b0;
            end
          end else begin
            state <= ST_DWELL;
          end
        end
        ST_DONE: begin
          if (i_start) begin
            state      <= ST_LOAD;
            o_step     <= 2'd0;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_pid_rst  <= 1'b1;
            o_motor_en <= 1'b0;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_FAULT: begin
          state      <= ST_FAULT;
          o_motor_en <= 1'b0;
          o_pid_rst  <= 1'b1;
          o_timeout  <= 1'b1;
          o_busy     <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          o_pid_rst  <= 1'b1;
          o_motor_en <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
          o_timeout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/setpoint_sequencer.md
SETPOINT_SEQUENCER -- requirements
Module: setpoint_sequencer

Interface
REQ-001 SHALL have parameters: POS_W, default 13, encoder position width.
REQ-002 SHALL have parameter SP_W, default 16, setpoint width.
REQ-003 SHALL have parameter TOL, default 10, in-position window in counts.
REQ-004 SHALL have parameter SETTLE_CYC, default 50000, consecutive in-window cycles needed to settle.
REQ-005 SHALL have parameter DWELL_CYC, default 1000000, hold time per step in cycles.
REQ-006 SHALL have parameter MOVE_TIMEOUT, default 50000000, maximum cycles from LOAD to settled.
REQ-007 SHALL have ports: Clk  in  1  system clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 i_start  in  1  begin sequence; level sampled each cycle.
REQ-010 i_abort  in  1  stop sequence, return to IDLE.
REQ-011 i_position  in  POS_W  decoder position count, unsigned.
REQ-012 o_setpoint  out  SP_W  target position to PID.
REQ-013 o_pid_rst  out  1  active-high PID reset, clears integrator.
REQ-014 o_motor_en  out  1  gates PWM drive pins.
REQ-015 o_step  out  2  current table index.
REQ-016 o_busy / o_done / o_timeout  out  1 each  status flags.

Function
REQ-017 Step table SHALL be 4 entries, index 0..3: 374, 748, 1122, 195.
REQ-018 Error SHALL be signed SP_W+1 bits: o_setpoint minus zero-extended i_position; in_win = |error| <= TOL.
REQ-019 States SHALL be IDLE, LOAD, MOVE, SETTLE, DWELL, DONE, FAULT.
REQ-020 All outputs SHALL be registered; a state change is reflected at the outputs one cycle after its triggering input.
REQ-021 IDLE: pid_rst=1, motor_en=0, busy=0; i_start=1 -> LOAD, step=0.
REQ-022 LOAD (exactly 1 cycle): o_setpoint <= table[step]; pid_rst=1; motor_en=0; MOVE timeout counter cleared -> MOVE.
REQ-023 MOVE: pid_rst=0, motor_en=1, busy=1; in_win -> SETTLE with settle counter cleared.
REQ-024 SETTLE: settle counter increments while in_win; reaching SETTLE_CYC -> DWELL; any !in_win cycle -> MOVE.
REQ-025 Timeout counter SHALL run through MOVE and SETTLE without being cleared by SETTLE->MOVE bounces; reaching MOVE_TIMEOUT -> FAULT, taking priority over the settle transition.
REQ-026 DWELL: drive stays on; after DWELL_CYC cycles, step==3 -> DONE, else step+1 -> LOAD.
REQ-027 DONE: motor_en=1 holding table[3]; done=1; busy=0; i_start=1 -> LOAD with step=0.
REQ-028 FAULT: motor_en=0, pid_rst=1, timeout=1; i_start ignored; only i_abort or rst exits, to IDLE.
REQ-029 i_abort=1 SHALL force IDLE next cycle from any state, overriding every other transition, including simultaneous i_start.
REQ-030 i_start SHALL be ignored in LOAD, MOVE, SETTLE, DWELL and FAULT.
REQ-031 Counters SHALL saturate at their terminal value and never wrap.
REQ-032 Error arithmetic SHALL be correct at i_position = 0 and i_position = 2^POS_W-1, with no sign aliasing.

Reset
REQ-033 rst SHALL force the following on the next edge: state=IDLE, o_setpoint=0, o_pid_rst=1, o_motor_en=0, o_step=0, busy=0, done=0, timeout=0, all counters 0.
REQ-034 rst asserted mid-move SHALL drop o_motor_en on the next edge.

Structure
REQ-035 Package motion_pkg SHALL hold: the state enum, the 4-entry step table, and the POS_W/SP_W defaults, shared with the top level and the PID.
REQ-036 One sub-module, err_window, SHALL compute signed error and in_win combinationally.

Verification
REQ-037 Bench parameters: TOL=10, SETTLE_CYC=4, DWELL_CYC=8, MOVE_TIMEOUT=200.
REQ-038 Scenario: start with position tracking the setpoint within 5 -> setpoint 374, 748, 1122, 195 in order, each held 8 cycles after a 4-cycle settle; then done=1, busy=0.
REQ-039 Scenario: position stuck at 0 after start -> FAULT after 200 cycles, motor_en=0, timeout=1; i_start ignored; i_abort -> IDLE.
REQ-040 Scenario: position toggles 370/390 during SETTLE -> SETTLE->MOVE bounce with no timeout reset; FAULT at 200 cycles.
REQ-041 Scenario: i_abort and i_start asserted together in IDLE and in DWELL -> IDLE, motor_en=0.
REQ-042 Scenario: rst pulsed during MOVE of step 2 -> all outputs at reset values next cycle.
REQ-043 Scenario: position 8191 with setpoint 195 -> in_win=0 and error = -7996.
